mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/armcpu_mem_pkg.sv | 30 +++
 rtl/mem_rr_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/armcpu_mem_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the FSM encoding, port ids and the read-wait default.
package armcpu_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WR_ISSUE = 3'd2,
    ST_WR_WAIT  = 3'd3,
    ST_DONE     = 3'd4
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_id_t;

  localparam int READ_WAIT_CYCLES_DEF = 1;

  // Wide enough for the largest legal read-wait setting (7).
  localparam int CNT_W = 3;

  // Fetches are always word-aligned before reaching memory.
  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin pick between fetch and data ports.
// Under contention the port not granted last time wins.
module mem_rr_pick
  import armcpu_mem_pkg::*;
(
  input  logic     if_req,
  input  logic     d_req,
  input  port_id_t last,
  output port_id_t grant
);

  // Lone requester wins outright; contention alternates.
  always_comb begin
    grant = PORT_IF;
    if (if_req && d_req) begin
      if (last == PORT_IF) grant = PORT_D;
      else                 grant = PORT_IF;
    end else if (d_req) begin
      grant = PORT_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one memory controller.
// One transaction at a time; acks are single-cycle pulses.
module mem_port_arbiter
  import armcpu_mem_pkg::*;
#(
  parameter int READ_WAIT_CYCLES = READ_WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        mem_is_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy
);

  localparam logic [CNT_W:0] RWC =
    (CNT_W+1)'(READ_WAIT_CYCLES);

  arb_state_t state;
  arb_state_t state_nxt;

  port_id_t owner;
  port_id_t last;
  port_id_t pick;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        err_q;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  logic grant;
  logic d_unaligned;
  logic rd_hit;

  mem_rr_pick u_pick (
    .if_req (if_req),
    .d_req  (d_req),
    .last   (last),
    .grant  (pick)
  );

  assign grant       = (if_req | d_req) & ~mem_busy;
  assign d_unaligned = d_addr[1:0] != 2'b00;
  assign cnt_inc     = {1'b0, cnt} + (CNT_W+1)'(1);
  assign rd_hit      = ~mem_busy && (cnt_inc == RWC);

  // State register, cleared straight to IDLE on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state: grant in IDLE, wait out memory, single DONE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant) begin
          if (pick == PORT_IF)  state_nxt = ST_READ;
          else if (d_unaligned) state_nxt = ST_DONE;
          else if (d_we)        state_nxt = ST_WR_ISSUE;
          else                  state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_hit) state_nxt = ST_DONE;
      end
      ST_WR_ISSUE: state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (!mem_busy) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state so reset clears them at once.
  always_comb begin
    if_ack       = 1'b0;
    d_ack        = 1'b0;
    d_err        = 1'b0;
    mem_is_write = 1'b0;
    if (state == ST_DONE) begin
      if_ack = owner == PORT_IF;
      d_ack  = owner == PORT_D;
      d_err  = (owner == PORT_D) && err_q;
    end
    if (state == ST_WR_ISSUE) mem_is_write = 1'b1;
  end

  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;

  // Grant latching, read-wait counting and rdata capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= PORT_IF;
      last       <= PORT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (grant) begin
            owner <= pick;
            last  <= pick;
            if (pick == PORT_D) begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              err_q   <= d_unaligned;
            end else begin
              addr_q <= word_align(if_addr);
              err_q  <= 1'b0;
            end
          end
        end
        ST_READ: begin
          if (mem_busy) cnt <= '0;
          else          cnt <= cnt_inc[CNT_W-1:0];
          if (rd_hit) begin
            if (owner == PORT_D) d_rdata_q  <= mem_data_out;
            else                 if_rdata_q <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a memory model.
// Directed latency cases followed by randomized traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        mem_is_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_busy = 1'b0;

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;
  logic rand_busy = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        d_q[$];
  logic [31:0] i_q[$];
  int          order[$];
  exp_t        de;
  logic [31:0] ie;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] noise = '0;
  logic [31:0] last_d_rd = '0;

  mem_port_arbiter #(.READ_WAIT_CYCLES(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_ack       (if_ack),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ack        (d_ack),
    .d_err        (d_err),
    .mem_is_write (mem_is_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .mem_busy     (mem_busy)
  );

  always #5 clk = ~clk;

  // Memory answers garbage while busy or for bad addresses.
  assign mem_data_out = mem_busy ? noise :
    mem[mem_addr[9:2]] ^
    (((mem_addr[1:0] != 2'b00) || (mem_addr[31:10] != '0))
      ? 32'hFFFF_FFFF : 32'h0);

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[64] = 32'hDEADBEEF;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    forever begin
      @(posedge clk);
      noise = $urandom;
      if (mem_is_write) mem[mem_addr[9:2]] = mem_data_in;
    end
  end

  always @(negedge clk) if (mem_is_write) wr_pulses++;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_busy) mem_busy = ($urandom_range(0, 2) == 0);
  end

  // Monitor: pop expectation on every ack and compare.
  always @(negedge clk) begin
    if (!rst && d_ack) begin
      order.push_back(1);
      total++;
      if (d_q.size() == 0) begin
        bad++;
        $display("FAIL d_ack_unexpected got=1 want=0");
      end else begin
        de = d_q.pop_front();
        if (d_rdata !== de.rdata || d_err !== de.err) begin
          bad++;
          $display("FAIL d_resp got rdata=%h err=%b want rdata=%h err=%b",
                   d_rdata, d_err, de.rdata, de.err);
        end
      end
    end
    if (!rst && if_ack) begin
      order.push_back(0);
      total++;
      if (i_q.size() == 0) begin
        bad++;
        $display("FAIL if_ack_unexpected got=1 want=0");
      end else begin
        ie = i_q.pop_front();
        if (if_rdata !== ie) begin
          bad++;
          $display("FAIL if_resp got=%h want=%h", if_rdata, ie);
        end
      end
    end
  end

  task automatic check(input string n, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, got, want);
    end
  endtask

  task automatic busy_script(input int s, input int n);
    if (s > 0) begin
      repeat (s) @(posedge clk);
      #1;
    end
    mem_busy = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    mem_busy = 1'b0;
  endtask

  // Called just after a rising edge; lat = cycles to ack.
  task automatic drive_d(input logic [31:0] a, input logic we,
                         input logic [31:0] wd, output int lat);
    exp_t e;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1;
      e.rdata = last_d_rd;
    end else if (we) begin
      e.err = 1'b0;
      e.rdata = last_d_rd;
      ref_mem[a[9:2]] = wd;
    end else begin
      e.err = 1'b0;
      e.rdata = ref_mem[a[9:2]];
      last_d_rd = e.rdata;
    end
    d_q.push_back(e);
    d_addr = a;
    d_we = we;
    d_wdata = wd;
    d_req = 1'b1;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (d_ack) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL d_timeout got=none want=ack");
    end
    @(posedge clk);
    #1;
    d_req = 1'b0;
  endtask

  task automatic drive_i(input logic [31:0] a, output int lat);
    i_q.push_back(ref_mem[a[9:2]]);
    if_addr = a;
    if_req = 1'b1;
    lat = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (if_ack) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      total++;
      bad++;
      $display("FAIL if_timeout got=none want=ack");
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    int l1, l2, l3, l4, w0;
    logic [3:0] ord;
    logic [31:0] a;

    repeat (2) @(posedge clk);
    #1;
    check("rst_is_write", 32'(mem_is_write), 0);
    check("rst_acks", {29'd0, if_ack, d_ack, d_err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_data_in, 0);
    check("rst_rdata", if_rdata | d_rdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Contention straight after reset: data first, then alternate.
    order.delete();
    fork
      begin
        drive_d(32'h080, 1'b0, 0, l1);
        drive_d(32'h084, 1'b0, 0, l2);
      end
      begin
        drive_i(32'h000, l3);
        drive_i(32'h004, l4);
      end
    join
    check("rr_count", order.size(), 4);
    ord = {order[0][0], order[1][0], order[2][0], order[3][0]};
    check("rr_order", 32'(ord), 32'b1010);

    drive_d(32'h100, 1'b0, 0, l1);
    check("rd_lat", l1, 2);
    check("rd_data", d_rdata, 32'hDEADBEEF);

    w0 = wr_pulses;
    drive_d(32'h202, 1'b1, 32'h55AA_55AA, l1);
    check("unal_lat", l1, 1);
    check("unal_nowrite", wr_pulses - w0, 0);

    w0 = wr_pulses;
    drive_d(32'h0C4, 1'b1, 32'hCAFE_0001, l1);
    check("wr0_lat", l1, 3);
    check("wr0_pulses", wr_pulses - w0, 1);

    w0 = wr_pulses;
    fork
      busy_script(2, 4);
      drive_d(32'h200, 1'b1, 32'h1234_5678, l1);
    join
    check("wr4_lat", l1, 7);
    check("wr4_pulses", wr_pulses - w0, 1);
    drive_d(32'h200, 1'b0, 0, l1);
    drive_d(32'h0C4, 1'b0, 0, l1);

    drive_i(32'h006, l1);
    check("if_unal_lat", l1, 2);

    fork
      busy_script(1, 2);
      drive_d(32'h088, 1'b0, 0, l1);
    join
    check("rd_busy_lat", l1, 4);

    fork
      busy_script(0, 3);
      drive_i(32'h00C, l1);
    join
    check("grant_wait_lat", l1, 5);

    // Reset while a write sits in WR_WAIT.
    d_addr = 32'h0C8;
    d_we = 1'b1;
    d_wdata = 32'h0BAD_0BAD;
    d_req = 1'b1;
    @(posedge clk);
    #1;
    mem_busy = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_write", 32'(mem_is_write), 0);
    check("mid_rst_acks", {30'd0, if_ack, d_ack}, 0);
    check("mid_rst_addr", mem_addr, 0);
    d_req = 1'b0;
    ref_mem[50] = 32'h0BAD_0BAD;
    last_d_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    fork
      drive_i(32'h008, l1);
      begin
        repeat (4) @(posedge clk);
        #1;
        mem_busy = 1'b0;
      end
    join
    check("post_rst_lat", l1, 6);

    // Randomized traffic on both ports with a jittery memory.
    rand_busy = 1'b1;
    fork
      begin
        int l;
        for (int k = 0; k < 40; k++) begin
          a = 32'h080 + 32'(4 * $urandom_range(0, 15));
          if ($urandom_range(0, 5) == 0)
            a[1:0] = 2'($urandom_range(1, 3));
          drive_d(a, 1'($urandom_range(0, 1)), $urandom, l);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        int l;
        for (int k = 0; k < 30; k++) begin
          a = 32'(4 * $urandom_range(0, 15));
          a[1:0] = 2'($urandom_range(0, 3));
          drive_i(a, l);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    rand_busy = 1'b0;
    #2;
    mem_busy = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("sb_drain", d_q.size() + i_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
